// File: rtl/midi_pkg.sv
// Shared constants and state type for the MIDI serial transmitter.
// Default timing assumes an 8 MHz system clock and 31250 baud.
package midi_pkg;

    localparam int MIDI_CLKS_PER_BIT_8MHZ = 256;
    localparam int MIDI_FRAME_BITS        = 10;
    localparam logic MIDI_LINE_IDLE       = 1'b1;

    // Start and stop bits take two of the frame bits; the rest are data bits 0..7.
    localparam logic [2:0] MIDI_LAST_DATA_BIT = 3'(MIDI_FRAME_BITS - 3);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } midi_tx_state_t;

endpackage

// File: rtl/midi_baud_gen.sv
// Bit-period counter for the MIDI transmitter.
// Held at zero while cleared; strobes in the last and next-to-last cycle of each bit.
module midi_baud_gen #(
    parameter int CLKS_PER_BIT = 256
) (
    input  logic clk,
    input  logic nreset,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST_CNT = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] PRE_CNT  = BW'(CLKS_PER_BIT - 2);

    logic [BW-1:0] bcnt;

    // Explicit wrap keeps bit periods exact for non-power-of-two divisors.
    always_ff @(posedge clk) begin
        if (!nreset || clear) begin
            bcnt <= '0;
        end else if (bcnt == LAST_CNT) begin
            bcnt <= '0;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    assign bit_end     = (bcnt == LAST_CNT);
    assign bit_pre_end = (bcnt == PRE_CNT);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI 8N1 serial transmitter with a one-byte holding buffer.
// The buffer lets multi-byte messages go out with no idle gap between frames.
module midi_uart_tx
    import midi_pkg::*;
#(
    parameter int CLKS_PER_BIT = MIDI_CLKS_PER_BIT_8MHZ
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       midi_tx,
    output logic       busy,
    output logic       frame_done
);

    midi_tx_state_t state;
    logic [7:0]     sr;
    logic [7:0]     hbuf;
    logic           hfull;
    logic [2:0]     bidx;
    logic           bit_end;
    logic           bit_pre_end;
    logic           accept;
    logic           stop_end;
    logic           to_hbuf;

    midi_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .nreset     (nreset),
        .clear      (state == ST_IDLE),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    assign tx_ready = nreset & ~hfull;
    assign accept   = tx_valid & tx_ready;
    assign stop_end = (state == ST_STOP) & bit_end;
    // A byte accepted in the final stop cycle goes straight to the shifter instead.
    assign to_hbuf  = accept & (state != ST_IDLE) & ~stop_end;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state      <= ST_IDLE;
            midi_tx    <= MIDI_LINE_IDLE;
            sr         <= '0;
            hbuf       <= '0;
            hfull      <= 1'b0;
            bidx       <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    midi_tx <= MIDI_LINE_IDLE;
                    if (accept) begin
                        sr      <= tx_data;
                        midi_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bidx    <= '0;
                        midi_tx <= sr[0];
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        sr <= sr >> 1;
                        if (bidx == MIDI_LAST_DATA_BIT) begin
                            midi_tx <= MIDI_LINE_IDLE;
                            state   <= ST_STOP;
                        end else begin
                            bidx    <= bidx + 3'd1;
                            midi_tx <= sr[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_pre_end) begin
                        frame_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (hfull) begin
                            sr      <= hbuf;
                            hfull   <= 1'b0;
                            midi_tx <= 1'b0;
                            state   <= ST_START;
                        end else if (accept) begin
                            sr      <= tx_data;
                            midi_tx <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    midi_tx <= MIDI_LINE_IDLE;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase

            if (to_hbuf) begin
                hbuf  <= tx_data;
                hfull <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Bench for midi_uart_tx: three instances (256, 4 and 2 clocks per bit) checked
// cycle by cycle against a frame-timeline model of the serial line.
module tb_midi_uart_tx;

    localparam int MAXC = 32768;

    typedef struct {
        int         inst;
        int         acc;
        int         start;
        logic [7:0] data;
    } frame_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] tx_data    [3];
    logic       tx_valid   [3];
    logic       tx_ready   [3];
    logic       midi_tx    [3];
    logic       busy       [3];
    logic       frame_done [3];

    frame_t     frames[$];
    int         last_end [3];
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] obs_v [3][MAXC];
    logic [3:0] exp_v [3][MAXC];

    always #5 clk = ~clk;

    midi_uart_tx #(.CLKS_PER_BIT(256)) u_dut256 (
        .clk(clk), .nreset(nreset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .midi_tx(midi_tx[0]), .busy(busy[0]), .frame_done(frame_done[0])
    );
    midi_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk(clk), .nreset(nreset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .midi_tx(midi_tx[1]), .busy(busy[1]), .frame_done(frame_done[1])
    );
    midi_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
        .clk(clk), .nreset(nreset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready[2]), .midi_tx(midi_tx[2]), .busy(busy[2]), .frame_done(frame_done[2])
    );

    function automatic int nclk(input int i);
        return (i == 0) ? 256 : (i == 1) ? 4 : 2;
    endfunction

    // Expected {midi_tx, busy, frame_done, tx_ready} in cycle t from the frame timeline:
    // a frame occupies 10 bit periods from its start; a byte is held in the buffer
    // between the cycle after its acceptance and the start of its own frame.
    function automatic logic [3:0] model_out(input int i, input int t);
        logic line;
        logic bz;
        logic dn;
        logic rdy;
        int   n;
        int   e;
        int   j;
        line = 1'b1;
        bz   = 1'b0;
        dn   = 1'b0;
        rdy  = nreset;
        n    = nclk(i);
        foreach (frames[k]) begin
            if (frames[k].inst == i) begin
                e = frames[k].start + 10 * n - 1;
                if (t >= frames[k].start && t <= e) begin
                    j    = (t - frames[k].start) / n;
                    bz   = 1'b1;
                    dn   = (t == e);
                    line = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : frames[k].data[j-1];
                end
                if (frames[k].acc < t && t < frames[k].start) begin
                    rdy = 1'b0;
                    bz  = 1'b1;
                end
            end
        end
        return {line, bz, dn, rdy};
    endfunction

    // Advance one clock: register any accept into the model, then record outputs.
    task automatic apply_stimulus();
        frame_t     f;
        logic [3:0] now_v;
        if (!nreset) begin
            frames.delete();
            foreach (last_end[i]) last_end[i] = -1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                now_v = model_out(i, cyc);
                if (tx_valid[i] && now_v[0]) begin
                    f.inst  = i;
                    f.acc   = cyc;
                    f.start = (last_end[i] + 1 > cyc + 1) ? last_end[i] + 1 : cyc + 1;
                    f.data  = tx_data[i];
                    last_end[i] = f.start + 10 * nclk(i) - 1;
                    frames.push_back(f);
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        for (int k = frames.size() - 1; k >= 0; k--) begin
            if (frames[k].start + 10 * nclk(frames[k].inst) - 1 < cyc) frames.delete(k);
        end
        for (int i = 0; i < 3; i++) begin
            obs_v[i][cyc] = {midi_tx[i], busy[i], frame_done[i], tx_ready[i]};
            exp_v[i][cyc] = model_out(i, cyc);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (obs_v[i][cyc] !== 4'b1000) begin
                fails++;
                $display("[TB] FAIL reset_state inst=%0d got=%b expected=1000", i, obs_v[i][cyc]);
            end
        end
        nreset = 1'b1;
        apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (obs_v[i][cyc] !== 4'b1001) begin
                fails++;
                $display("[TB] FAIL reset_release inst=%0d got=%b expected=1001", i, obs_v[i][cyc]);
            end
        end
    endtask

    task automatic test_single_byte();
        int   t0;
        int   s;
        int   dcnt;
        int   bcnt;
        logic seq [10];
        seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        t0 = cyc;
        s  = cyc + 1;
        tx_data[0]  = 8'h90;
        tx_valid[0] = 1'b1;
        apply_stimulus();
        tx_valid[0] = 1'b0;
        repeat (2600) apply_stimulus();
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (obs_v[0][s + k * 256 + 128][3] !== seq[k]) begin
                fails++;
                $display("[TB] FAIL single_bit bit=%0d got=%b expected=%b", k, obs_v[0][s + k * 256 + 128][3], seq[k]);
            end
        end
        dcnt = 0;
        bcnt = 0;
        for (int t = t0 + 1; t <= cyc; t++) begin
            dcnt += int'(obs_v[0][t][1]);
            bcnt += int'(obs_v[0][t][2]);
            tests++;
            if (obs_v[0][t] !== exp_v[0][t]) begin
                fails++;
                $display("[TB] FAIL single_trace cyc=%0d got=%b expected=%b", t, obs_v[0][t], exp_v[0][t]);
            end
        end
        tests++;
        if (dcnt !== 1 || obs_v[0][s + 2559][1] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_done count=%0d at_end=%b expected count=1 at_end=1", dcnt, obs_v[0][s + 2559][1]);
        end
        tests++;
        if (bcnt !== 2560) begin
            fails++;
            $display("[TB] FAIL single_busy got=%0d expected=2560", bcnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [3];
        int         idx;
        int         t0;
        int         s;
        int         dcnt;
        int         bcnt;
        logic       acc;
        msg = '{8'h90, 8'h3C, 8'h64};
        idx = 0;
        t0  = cyc;
        s   = cyc + 1;
        tx_data[0]  = msg[0];
        tx_valid[0] = 1'b1;
        for (int g = 0; g < 9000 && idx < 3; g++) begin
            acc = tx_ready[0];
            apply_stimulus();
            if (acc) begin
                idx++;
                if (idx < 3) tx_data[0] = msg[idx];
                else tx_valid[0] = 1'b0;
            end
        end
        tx_valid[0] = 1'b0;
        tests++;
        if (idx != 3) begin
            fails++;
            $display("[TB] FAIL b2b_accepts got=%0d expected=3", idx);
        end
        while (cyc < s + 7700) apply_stimulus();
        dcnt = 0;
        bcnt = 0;
        for (int t = t0 + 1; t <= cyc; t++) begin
            dcnt += int'(obs_v[0][t][1]);
            bcnt += int'(obs_v[0][t][2]);
            tests++;
            if (obs_v[0][t] !== exp_v[0][t]) begin
                fails++;
                $display("[TB] FAIL b2b_trace cyc=%0d got=%b expected=%b", t, obs_v[0][t], exp_v[0][t]);
            end
        end
        tests++;
        if (dcnt !== 3 || bcnt !== 7680) begin
            fails++;
            $display("[TB] FAIL b2b_counts done=%0d busy=%0d expected done=3 busy=7680", dcnt, bcnt);
        end
        tests++;
        if (obs_v[0][s + 2560][3] !== 1'b0 || obs_v[0][s + 5120][3] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_no_gap got=%b%b expected=00", obs_v[0][s + 2560][3], obs_v[0][s + 5120][3]);
        end
    endtask

    task automatic test_buffer_full();
        logic [7:0] got[$];
        logic [7:0] b;
        int         t0;
        int         s;
        int         t;
        t0 = cyc;
        s  = cyc + 1;
        tx_data[0]  = 8'h80;
        tx_valid[0] = 1'b1;
        apply_stimulus();
        tx_valid[0] = 1'b0;
        repeat (500) apply_stimulus();
        tx_data[0]  = 8'h40;
        tx_valid[0] = 1'b1;
        apply_stimulus();
        tx_data[0]  = 8'hFF;
        repeat (200) apply_stimulus();
        tx_valid[0] = 1'b0;
        while (cyc < s + 5170) apply_stimulus();
        t = t0 + 1;
        while (t + 2560 <= cyc) begin
            if (obs_v[0][t][3] === 1'b0 && obs_v[0][t - 1][3] === 1'b1) begin
                for (int k = 0; k < 8; k++) b[k] = obs_v[0][t + (k + 1) * 256 + 128][3];
                got.push_back(b);
                t += 2559;
            end
            t++;
        end
        tests++;
        if (got.size() != 2) begin
            fails++;
            $display("[TB] FAIL bufful_frames got=%0d expected=2", got.size());
        end else begin
            tests++;
            if (got[0] !== 8'h80 || got[1] !== 8'h40) begin
                fails++;
                $display("[TB] FAIL bufful_bytes got=%h,%h expected=80,40", got[0], got[1]);
            end
        end
        for (int u = t0 + 1; u <= cyc; u++) begin
            tests++;
            if (obs_v[0][u] !== exp_v[0][u]) begin
                fails++;
                $display("[TB] FAIL bufful_trace cyc=%0d got=%b expected=%b", u, obs_v[0][u], exp_v[0][u]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int t0;
        int s;
        int rel;
        int lows;
        int bz;
        t0 = cyc;
        s  = cyc + 1;
        tx_data[0]  = 8'hA5;
        tx_valid[0] = 1'b1;
        apply_stimulus();
        tx_valid[0] = 1'b0;
        repeat (100) apply_stimulus();
        tx_data[0]  = 8'h33;
        tx_valid[0] = 1'b1;
        apply_stimulus();
        tx_valid[0] = 1'b0;
        while (cyc < s + 4 * 256 + 100) apply_stimulus();
        nreset = 1'b0;
        apply_stimulus();
        tests++;
        if (obs_v[0][cyc - 1][2] !== 1'b1 || obs_v[0][cyc - 1][0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_before busy=%b ready=%b expected busy=1 ready=0", obs_v[0][cyc - 1][2], obs_v[0][cyc - 1][0]);
        end
        tests++;
        if (obs_v[0][cyc][3] !== 1'b1 || obs_v[0][cyc][2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_after line=%b busy=%b expected line=1 busy=0", obs_v[0][cyc][3], obs_v[0][cyc][2]);
        end
        nreset = 1'b1;
        rel = cyc;
        repeat (3000) apply_stimulus();
        lows = 0;
        bz   = 0;
        for (int t = rel + 1; t <= cyc; t++) begin
            lows += int'(!obs_v[0][t][3]);
            bz   += int'(obs_v[0][t][2]);
        end
        tests++;
        if (lows != 0 || bz != 0) begin
            fails++;
            $display("[TB] FAIL midrst_quiet low_cycles=%0d busy_cycles=%0d expected 0 and 0", lows, bz);
        end
        for (int t = t0 + 1; t <= cyc; t++) begin
            tests++;
            if (obs_v[0][t] !== exp_v[0][t]) begin
                fails++;
                $display("[TB] FAIL midrst_trace cyc=%0d got=%b expected=%b", t, obs_v[0][t], exp_v[0][t]);
            end
        end
    endtask

    task automatic test_stop_accept();
        logic [7:0] d;
        logic       e;
        int         t0;
        int         s;
        d  = 8'h55;
        t0 = cyc;
        s  = cyc + 1;
        tx_data[1]  = 8'hC3;
        tx_valid[1] = 1'b1;
        apply_stimulus();
        tx_valid[1] = 1'b0;
        while (cyc < s + 39) apply_stimulus();
        tx_data[1]  = d;
        tx_valid[1] = 1'b1;
        apply_stimulus();
        tx_valid[1] = 1'b0;
        repeat (50) apply_stimulus();
        tests++;
        if (obs_v[1][s + 39][1] !== 1'b1 || obs_v[1][s + 40][3] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stopacc_edge done=%b next_line=%b expected done=1 next_line=0", obs_v[1][s + 39][1], obs_v[1][s + 40][3]);
        end
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k - 1];
            tests++;
            if (obs_v[1][s + 40 + 4 * k + 2][3] !== e) begin
                fails++;
                $display("[TB] FAIL stopacc_bit bit=%0d got=%b expected=%b", k, obs_v[1][s + 40 + 4 * k + 2][3], e);
            end
        end
        for (int t = t0 + 1; t <= cyc; t++) begin
            tests++;
            if (obs_v[1][t] !== exp_v[1][t]) begin
                fails++;
                $display("[TB] FAIL stopacc_trace cyc=%0d got=%b expected=%b", t, obs_v[1][t], exp_v[1][t]);
            end
        end
    endtask

    task automatic test_param();
        int   t0;
        int   s;
        int   dcnt;
        logic e;
        t0 = cyc;
        s  = cyc + 1;
        tx_data[2]  = 8'h01;
        tx_valid[2] = 1'b1;
        apply_stimulus();
        tx_valid[2] = 1'b0;
        repeat (30) apply_stimulus();
        for (int t = 0; t < 20; t++) begin
            e = (t / 2 == 1 || t / 2 == 9);
            tests++;
            if (obs_v[2][s + t][3] !== e) begin
                fails++;
                $display("[TB] FAIL param_line offset=%0d got=%b expected=%b", t, obs_v[2][s + t][3], e);
            end
        end
        dcnt = 0;
        for (int t = t0 + 1; t <= cyc; t++) dcnt += int'(obs_v[2][t][1]);
        tests++;
        if (dcnt != 1 || obs_v[2][s + 19][1] !== 1'b1 || obs_v[2][s + 20][2] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL param_frame done=%0d last_done=%b busy_after=%b expected 1,1,0", dcnt, obs_v[2][s + 19][1], obs_v[2][s + 20][2]);
        end
        for (int t = t0 + 1; t <= cyc; t++) begin
            tests++;
            if (obs_v[2][t] !== exp_v[2][t]) begin
                fails++;
                $display("[TB] FAIL param_trace cyc=%0d got=%b expected=%b", t, obs_v[2][t], exp_v[2][t]);
            end
        end
    endtask

    task automatic test_random();
        int t0;
        t0 = cyc;
        for (int k = 0; k < 4000; k++) begin
            for (int i = 1; i < 3; i++) begin
                if ($urandom_range(0, 3) == 0) tx_valid[i] = ~tx_valid[i];
                if ($urandom_range(0, 1) == 1) tx_data[i] = 8'($urandom);
            end
            nreset = !(k == 1500 || k == 2900);
            apply_stimulus();
        end
        nreset = 1'b1;
        tx_valid[1] = 1'b0;
        tx_valid[2] = 1'b0;
        repeat (100) apply_stimulus();
        for (int i = 0; i < 3; i++) begin
            for (int t = t0 + 1; t <= cyc; t++) begin
                tests++;
                if (obs_v[i][t] !== exp_v[i][t]) begin
                    fails++;
                    $display("[TB] FAIL random_trace inst=%0d cyc=%0d got=%b expected=%b", i, t, obs_v[i][t], exp_v[i][t]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            tx_data[i]  = 8'h00;
            tx_valid[i] = 1'b0;
            last_end[i] = -1;
        end
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_buffer_full();
        test_reset_midframe();
        test_stop_accept();
        test_param();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

MIDI serial transmitter: accepts bytes over a valid/ready handshake and serializes each one onto a MIDI output line as a standard 8N1 frame (start bit, 8 data bits LSB first, stop bit) at 31250 baud, derived from the 8 MHz system clock. A one-byte holding buffer allows back-to-back frames with no idle gap, which multi-byte MIDI messages need. It sits between internal message sources (merge/route logic, SPI-configured generators) and a `midi_out` pin. It is the transmit counterpart of the synchronized MIDI input path.

## Interface
- `CLKS_PER_BIT`, 256: clock cycles per bit (8 MHz / 31250). Legal values are 2 or more.
- `clk`  in  1  system clock, 8 MHz, from the MCU.
- `nreset`  in  1  reset; synchronous, active-low.
- `tx_data`  in  8  byte to send; sampled when `tx_valid & tx_ready`.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  block can accept a byte this cycle (holding buffer empty).
- `midi_tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is in progress, or a byte is waiting in the buffer.
- `frame_done`  out  1  one-cycle pulse in the last cycle of each stop bit.

## Operation
- **States:** IDLE, START, DATA, STOP.
  - Baud counter `bcnt` runs 0..CLKS_PER_BIT-1.
  - Bit index `bidx` is 3 bits wide; `bcnt` is `$clog2(CLKS_PER_BIT)` bits wide.
  - Shift register `sr` is 8 bits; holding buffer is `hbuf` plus `hfull`.
- **IDLE:** `midi_tx`=1.
  - On accept, the byte loads directly into `sr` (bypassing `hbuf`), `bcnt`=0, and the state goes to START.
- **START:** `midi_tx`=0 for CLKS_PER_BIT cycles, then DATA with `bidx`=0.
- **DATA:** `midi_tx`=`sr[0]` for CLKS_PER_BIT cycles per bit.
  - At the end of each bit, `sr` shifts right.
  - After bit 7 (`bidx`=7), go to STOP.
- **STOP:** `midi_tx`=1 for CLKS_PER_BIT cycles. In the last cycle, `frame_done`=1, then:
  - If `hfull`: load `hbuf` into `sr`, clear `hfull`, go to START (no gap).
  - Otherwise, if an accept happens this same cycle: load `tx_data` into `sr`, go to START.
  - Otherwise: go to IDLE.
- **Accept outside IDLE:** while in START/DATA/STOP with `hfull`=0, an accept writes `hbuf` and sets `hfull`.
- **Ready rule:** `tx_ready` = `!hfull`, gated low while `nreset`=0.
  - `tx_data` and `tx_valid` are ignored when `tx_ready`=0.
  - `tx_valid` may drop without being accepted; no byte is lost or duplicated.
- **Busy rule:** `busy` = (state != IDLE) | `hfull`.
- **Reset** (including mid-frame): next edge forces IDLE, `midi_tx`=1, `hfull`=0, counters 0, `frame_done`=0.
  - The partial frame is truncated and the buffered byte is discarded.
- **Reset values:** `midi_tx`=1, `tx_ready`=0 while `nreset` low, then 1 from the first cycle after release; `busy`=0, `frame_done`=0.

## Timing
- All outputs are registered except `tx_ready`, which is combinational from `hfull` and `nreset`.
- **Latency:** accept at edge N puts `midi_tx` low from cycle N+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles (2560 at the default).
  - Each bit lasts exactly CLKS_PER_BIT cycles, with no drift across frames.
- **Back-to-back:** the next start bit begins the cycle after the previous stop bit's last cycle, so 3 bytes take 30×CLKS_PER_BIT cycles.
- **Buffer release:** `tx_ready` returns high the cycle after `hbuf` moves to `sr`.
- **Throughput:** one byte per frame; a second accept while `hfull`=1 is impossible by construction.

## Structure
- **Package `midi_pkg`:**
  - `MIDI_CLKS_PER_BIT_8MHZ`=256.
  - State enum (IDLE, START, DATA, STOP).
  - `MIDI_FRAME_BITS`=10.
  - Idle line level constant (1).
- **Sub-module `midi_baud_gen`:** baud counter with synchronous clear (on frame start); emits a `bit_end` strobe in the last cycle of each bit.
- **Top level:** the FSM, shift register and holding buffer live in `midi_uart_tx` itself.

## Test plan
- **Single byte:** reset, then send 0x90. `midi_tx` must read 0,0,0,0,0,1,0,0,1,1 (start, LSB-first data, stop), each bit held 256 cycles. `frame_done` pulses once at cycle 2560 after the accept. `busy` is high for 2560 cycles.
- **Back-to-back:** hold `tx_valid` with 0x90, 0x3C, 0x64 (advance on ready). Expect 7680 contiguous cycles with no high gap between frames beyond the stop bits, 3 `frame_done` pulses, and `tx_ready` low while the buffer is full.
- **Buffer full:** send 0x80, then 0x40 mid-frame, then offer 0xFF while `hfull`=1. 0xFF is ignored, and exactly 0x80 then 0x40 appear on the line.
- **Reset mid-frame:** assert `nreset`=0 during DATA bit 3 of 0xA5 with a byte buffered. The next edge gives `midi_tx`=1 and `busy`=0, and no further frame follows release.
- **Stop-cycle accept:** with `CLKS_PER_BIT`=4, accept 0x55 exactly in the last STOP cycle with the buffer empty. The start bit follows in the next cycle and the line sequence is correct.
- **Parameter check:** with `CLKS_PER_BIT`=2, send 0x01. Expect a 20-cycle frame, bit 0 high for 2 cycles, all other data bits low.
